// File: rtl/bram2rgb_if.sv
// bram2rgb_if: BRAM read port between the frame buffer and bram2rgb.
// master drives the read request; slave returns the {r,g,b} word.
interface bram2rgb_if #(
  parameter int ADDR_W = 17
);
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [23:0]       rd_data;

  modport master (
    output rd_en,
    output rd_addr,
    input  rd_data
  );

  modport slave (
    input  rd_en,
    input  rd_addr,
    output rd_data
  );
endinterface

// File: rtl/bram2rgb.sv
// bram2rgb: display timing plus 2x upscaled BRAM fetch for rgb2dvi.
// Optional BRAM2RGB_TEST_PATTERN_EN adds i_pattern colour bars.
module bram2rgb #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0,
  parameter int SHIFT    = 1,
  parameter int RD_LAT   = 1,
  parameter int ADDR_W   = 17
) (
  input  logic       pclk,
  input  logic       rstb,
  input  logic       en,
`ifdef BRAM2RGB_TEST_PATTERN_EN
  input  logic       i_pattern,
`endif
  bram2rgb_if.master bram,
  output logic       o_hsync,
  output logic       o_vsync,
  output logic       o_vde,
  output logic [7:0] rgb_r,
  output logic [7:0] rgb_g,
  output logic [7:0] rgb_b,
  output logic       start_frame
);

  localparam int H_TOTAL = H_ACTIVE + H_FP
                         + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP
                         + V_SYNC + V_BP;
  localparam int HW    = $clog2(H_TOTAL);
  localparam int VW    = $clog2(V_TOTAL);
  localparam int SRC_W = H_ACTIVE >> SHIFT;
  localparam int MASK  = (1 << SHIFT) - 1;
  localparam int DEPTH = 1 + RD_LAT;

  localparam logic [HW-1:0] H_LAST =
    HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST =
    VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT =
    HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_ACT =
    VW'(V_ACTIVE);
  localparam logic [HW-1:0] HS_ON =
    HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_OFF =
    HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] VS_ON =
    VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_OFF =
    VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] V_MASK =
    VW'(MASK);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic        sf;
    logic        pat;
    logic [23:0] bar;
  } tim_t;

  state_t            state_q, state_d;
  logic [HW-1:0]     h_cnt_q, h_cnt_d;
  logic [VW-1:0]     v_cnt_q, v_cnt_d;
  logic [ADDR_W-1:0] line_base_q, line_base_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  tim_t              pipe_q [DEPTH];
  tim_t              pipe_d [DEPTH];

  logic        run;
  logic        act;
  logic        frame_end;
  logic        line_end;
  logic        pat_sel;
  logic [23:0] bar_rgb;
  logic [23:0] pix;
  tim_t        last;

`ifdef BRAM2RGB_TEST_PATTERN_EN
  logic [2:0] bar_idx;

  // Pick the colour bar under the current column.
  always_comb begin
    bar_idx = '0;
    for (int k = 1; k < 8; k++) begin
      if (h_cnt_q >= HW'(k * (H_ACTIVE / 8)))
        bar_idx = 3'(k);
    end
  end

  assign pat_sel = i_pattern;
  assign bar_rgb = {
    {8{~bar_idx[1]}},
    {8{~bar_idx[2]}},
    {8{~bar_idx[0]}}
  };
`else
  assign pat_sel = 1'b0;
  assign bar_rgb = 24'h0;
`endif

  assign run = (state_q == RUN);
  assign act = run
             && (h_cnt_q < H_ACT)
             && (v_cnt_q < V_ACT);
  assign frame_end = (h_cnt_q == H_LAST)
                   && (v_cnt_q == V_LAST);
  assign line_end = (h_cnt_q == H_ACT - 1'b1)
                  && (v_cnt_q < V_ACT)
                  && ((v_cnt_q & V_MASK) == V_MASK);

  // Run/idle control, raster counters, source line base.
  always_comb begin
    state_d     = state_q;
    h_cnt_d     = h_cnt_q;
    v_cnt_d     = v_cnt_q;
    line_base_d = line_base_q;
    unique case (state_q)
      IDLE: begin
        h_cnt_d     = '0;
        v_cnt_d     = '0;
        line_base_d = '0;
        if (en)
          state_d = RUN;
      end
      RUN: begin
        if (h_cnt_q == H_LAST) begin
          h_cnt_d = '0;
          if (v_cnt_q == V_LAST)
            v_cnt_d = '0;
          else
            v_cnt_d = v_cnt_q + 1'b1;
        end else begin
          h_cnt_d = h_cnt_q + 1'b1;
        end
        if (frame_end) begin
          line_base_d = '0;
          if (!en)
            state_d = IDLE;
        end else if (line_end) begin
          line_base_d = line_base_q
                      + ADDR_W'(SRC_W);
        end
      end
    endcase
  end

  // Read request and timing delay line.
  always_comb begin
    rd_en_d   = act && !pat_sel;
    rd_addr_d = '0;
    if (act)
      rd_addr_d = line_base_q
                + ADDR_W'(h_cnt_q >> SHIFT);
    pipe_d[0]     = '0;
    pipe_d[0].hs  = run
                  && (h_cnt_q >= HS_ON)
                  && (h_cnt_q < HS_OFF);
    pipe_d[0].vs  = run
                  && (v_cnt_q >= VS_ON)
                  && (v_cnt_q < VS_OFF);
    pipe_d[0].de  = act;
    pipe_d[0].sf  = run
                  && (h_cnt_q == '0)
                  && (v_cnt_q == '0);
    pipe_d[0].pat = pat_sel;
    pipe_d[0].bar = bar_rgb;
    for (int i = 1; i < DEPTH; i++)
      pipe_d[i] = pipe_q[i-1];
  end

  // State, counters and pipeline registers.
  always_ff @(posedge pclk or negedge rstb) begin
    if (!rstb) begin
      state_q     <= IDLE;
      h_cnt_q     <= '0;
      v_cnt_q     <= '0;
      line_base_q <= '0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      for (int i = 0; i < DEPTH; i++)
        pipe_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      h_cnt_q     <= h_cnt_d;
      v_cnt_q     <= v_cnt_d;
      line_base_q <= line_base_d;
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
      for (int i = 0; i < DEPTH; i++)
        pipe_q[i] <= pipe_d[i];
    end
  end

  assign last = pipe_q[DEPTH-1];
  assign pix  = last.pat ? last.bar
                         : bram.rd_data;

  assign bram.rd_en   = rd_en_q;
  assign bram.rd_addr = rd_addr_q;

  assign o_hsync     = last.hs ^ ~SYNC_POL;
  assign o_vsync     = last.vs ^ ~SYNC_POL;
  assign o_vde       = last.de;
  assign start_frame = last.sf;
  assign {rgb_r, rgb_g, rgb_b} =
    last.de ? pix : 24'h0;

endmodule

// File: tb/tb_bram2rgb.sv
// tb_bram2rgb: random run/stop stimulus on two instances
// (RD_LAT 1 and 2) against a raster-level reference model.
module tb_bram2rgb;

  localparam int HA = 64;
  localparam int HF = 4;
  localparam int HS = 8;
  localparam int HB = 4;
  localparam int VA = 16;
  localparam int VF = 2;
  localparam int VS = 2;
  localparam int VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int SH = 1;
  localparam int AW = 17;
  localparam int SRCW = HA / (2 ** SH);
  localparam int FRAME = HT * VT;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic        sf;
    logic [23:0] rgb;
  } exp_t;

  logic pclk = 1'b0;
  logic rstb = 1'b0;
  logic en   = 1'b0;
`ifdef BRAM2RGB_TEST_PATTERN_EN
  logic pat  = 1'b0;
  logic [23:0] bars [8] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF,
    24'h00FF00, 24'hFF00FF, 24'hFF0000,
    24'h0000FF, 24'h000000
  };
`endif

  always #5 pclk = ~pclk;

  bram2rgb_if #(.ADDR_W(AW)) bif1 ();
  bram2rgb_if #(.ADDR_W(AW)) bif2 ();

  logic       hs1, vs1, de1, sf1;
  logic       hs2, vs2, de2, sf2;
  logic [7:0] r1, g1, b1, r2, g2, b2;

  bram2rgb #(
    .H_ACTIVE(HA), .H_FP(HF),
    .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF),
    .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b0), .SHIFT(SH),
    .RD_LAT(1), .ADDR_W(AW)
  ) u_dut1 (
    .pclk(pclk), .rstb(rstb), .en(en),
`ifdef BRAM2RGB_TEST_PATTERN_EN
    .i_pattern(pat),
`endif
    .bram(bif1),
    .o_hsync(hs1), .o_vsync(vs1),
    .o_vde(de1),
    .rgb_r(r1), .rgb_g(g1), .rgb_b(b1),
    .start_frame(sf1)
  );

  bram2rgb #(
    .H_ACTIVE(HA), .H_FP(HF),
    .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF),
    .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b0), .SHIFT(SH),
    .RD_LAT(2), .ADDR_W(AW)
  ) u_dut2 (
    .pclk(pclk), .rstb(rstb), .en(en),
`ifdef BRAM2RGB_TEST_PATTERN_EN
    .i_pattern(pat),
`endif
    .bram(bif2),
    .o_hsync(hs2), .o_vsync(vs2),
    .o_vde(de2),
    .rgb_r(r2), .rgb_g(g2), .rgb_b(b2),
    .start_frame(sf2)
  );

  function automatic logic [23:0] mem(
    input logic [AW-1:0] a
  );
    logic [7:0] lo;
    lo = a[7:0];
    return {lo, ~lo, 8'h5A};
  endfunction

  logic [23:0] m1_q, m2a_q, m2b_q;

  always @(posedge pclk) begin
    if (bif1.rd_en)
      m1_q <= mem(bif1.rd_addr);
  end

  always @(posedge pclk) begin
    if (bif2.rd_en)
      m2a_q <= mem(bif2.rd_addr);
    m2b_q <= m2a_q;
  end

  assign bif1.rd_data = m1_q;
  assign bif2.rd_data = m2b_q;

  int   n_vec = 0;
  int   n_err = 0;
  int   mh = 0;
  int   mv = 0;
  bit   mrun = 1'b0;
  bit   erd_en = 1'b0;
  int   erd_addr = 0;
  exp_t q1 [$];
  exp_t q2 [$];

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_t idle;
    idle = '0;
    idle.hs = 1'b1;
    idle.vs = 1'b1;
    mrun = 1'b0;
    mh = 0;
    mv = 0;
    erd_en = 1'b0;
    erd_addr = 0;
    q1 = {};
    q2 = {};
    repeat (2) q1.push_back(idle);
    repeat (3) q2.push_back(idle);
  endtask

  task automatic step();
    exp_t e;
    bit   act;
    bit   use_pat;
    int   a;
    @(posedge pclk);
    if (!rstb) begin
      model_reset();
    end else begin
      use_pat = 1'b0;
`ifdef BRAM2RGB_TEST_PATTERN_EN
      use_pat = pat;
`endif
      act = mrun && mh < HA && mv < VA;
      a = (mv / (2 ** SH)) * SRCW
        + mh / (2 ** SH);
      e = '0;
      e.hs = !(mrun && mh >= HA + HF
               && mh < HA + HF + HS);
      e.vs = !(mrun && mv >= VA + VF
               && mv < VA + VF + VS);
      e.de = act;
      e.sf = mrun && mh == 0 && mv == 0;
      if (act)
        e.rgb = mem(AW'(a));
`ifdef BRAM2RGB_TEST_PATTERN_EN
      if (act && use_pat)
        e.rgb = bars[mh / (HA / 8)];
`endif
      erd_en = act && !use_pat;
      erd_addr = a;
      q1.push_back(e);
      q2.push_back(e);
      void'(q1.pop_front());
      void'(q2.pop_front());
      if (!mrun) begin
        if (en) mrun = 1'b1;
      end else if (mh == HT - 1) begin
        mh = 0;
        if (mv == VT - 1) begin
          mv = 0;
          if (!en) mrun = 1'b0;
        end else begin
          mv++;
        end
      end else begin
        mh++;
      end
    end
    @(negedge pclk);
    check("hs1", hs1, q1[0].hs);
    check("vs1", vs1, q1[0].vs);
    check("de1", de1, q1[0].de);
    check("sf1", sf1, q1[0].sf);
    check("rgb1", {r1, g1, b1}, q1[0].rgb);
    check("rden1", bif1.rd_en, erd_en);
    if (erd_en)
      check("addr1", bif1.rd_addr, erd_addr);
    check("hs2", hs2, q2[0].hs);
    check("vs2", vs2, q2[0].vs);
    check("de2", de2, q2[0].de);
    check("sf2", sf2, q2[0].sf);
    check("rgb2", {r2, g2, b2}, q2[0].rgb);
    check("rden2", bif2.rd_en, erd_en);
    if (erd_en)
      check("addr2", bif2.rd_addr, erd_addr);
  endtask

  task automatic wait_sf();
    int n;
    n = 0;
    while (!sf1 && n < 2 * FRAME) begin
      step();
      n++;
    end
    check("sf_wait", sf1, 1'b1);
  endtask

  task automatic window_2f();
    int c_de, c_de2, c_hs, c_vs;
    int c_rd, c_sf, max_a;
    c_de = 0; c_de2 = 0; c_hs = 0;
    c_vs = 0; c_rd = 0; c_sf = 0;
    max_a = 0;
    wait_sf();
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (i > 0) step();
      c_de  += int'(de1);
      c_de2 += int'(de2);
      c_hs  += int'(!hs1);
      c_vs  += int'(!vs1);
      c_sf  += int'(sf1);
      if (bif1.rd_en) begin
        c_rd++;
        if (int'(bif1.rd_addr) > max_a)
          max_a = int'(bif1.rd_addr);
      end
    end
    check("cnt_de", c_de, 2 * HA * VA);
    check("cnt_de2", c_de2, 2 * HA * VA);
    check("cnt_hs", c_hs, 2 * HS * VT);
    check("cnt_vs", c_vs, 2 * VS * HT);
    check("cnt_rd", c_rd, 2 * HA * VA);
    check("cnt_sf", c_sf, 2);
    check("max_addr", max_a,
          SRCW * (VA / (2 ** SH)) - 1);
  endtask

  initial begin
    rstb = 1'b0;
    en = 1'b1;
    repeat (5) step();
    rstb = 1'b1;
    window_2f();

    for (int n = 0; n < 2 * FRAME; n++) begin
      if (mv == VA / 2) break;
      step();
    end
    en = 1'b0;
    for (int n = 0; n < 2 * FRAME; n++) begin
      if (!mrun) break;
      step();
      if (mh == HT - 1 && mv == VT - 1)
        en = 1'b0;
      else
        en = ($urandom_range(0, 1) == 1);
    end
    en = 1'b0;
    repeat (20 + $urandom_range(0, 30)) step();
    en = 1'b1;
    wait_sf();
    repeat (100) step();

    for (int n = 0; n < 4 * FRAME; n++) begin
      en = ($urandom_range(0, 3) != 0);
      step();
    end

    en = 1'b1;
    for (int n = 0; n < 2 * FRAME; n++) begin
      if (mrun && mv == 5) break;
      step();
    end
    rstb = 1'b0;
    repeat (3) step();
    rstb = 1'b1;
    wait_sf();
    repeat (FRAME) step();

`ifdef BRAM2RGB_TEST_PATTERN_EN
    pat = 1'b1;
    wait_sf();
    repeat (FRAME) step();
    pat = 1'b0;
    repeat (FRAME) step();
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bram2rgb.md
Name: bram2rgb

Overview:
- Read side of the video frame buffer; the opposite end of the HDMI-in path that writes downscaled pixels into BRAM.
- Generates 640x480@60 display timing on the pixel clock.
- Fetches 320x240 24-bit pixels from BRAM and upscales 2x by pixel and line replication.
- Drives RGB, hsync, vsync and vde, aligned, into the downstream rgb2dvi transmitter.

Parameters:
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, active lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync width
- V_BP, 33, vertical back porch
- SYNC_POL, 0, sync active level (0 = active-low)
- SHIFT, 1, upscale factor log2
- RD_LAT, 1, BRAM read latency in cycles (1 or 2)
- ADDR_W, 17, BRAM address width

Ports:
- pclk  in  1  pixel clock, 25.2 MHz
- rstb  in  1  asynchronous active-low reset
- en  in  1  run request; sampled at frame boundaries
- rd_en  out  1  BRAM read enable
- rd_addr  out  ADDR_W  BRAM read address
- rd_data  in  24  BRAM data {r,g,b}, valid RD_LAT cycles after rd_en
- o_hsync  out  1  horizontal sync
- o_vsync  out  1  vertical sync
- o_vde  out  1  video data enable
- rgb_r, rgb_g, rgb_b  out  8 each  pixel colour
- start_frame  out  1  one-cycle pulse with first active pixel of each frame

Behaviour:
- Reset, asynchronous, rstb low:
  - State IDLE; h_cnt = v_cnt = 0; rd_en = 0; rd_addr = 0.
  - o_vde = 0; rgb = 0; start_frame = 0; o_hsync = o_vsync = ~SYNC_POL (inactive).
- Timing:
  - h_cnt runs 0..H_TOTAL-1, H_TOTAL = 800.
  - v_cnt runs 0..V_TOTAL-1, V_TOTAL = 525; v_cnt increments when h_cnt wraps.
  - Active region: h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
  - hsync asserted for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - vsync asserted for v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), over whole lines.
- State machine:
  - IDLE: counters held at 0; outputs at reset values. Go to RUN when en = 1.
  - RUN: counters free-run. If en = 0 at the last cycle of a frame (h_cnt = 799, v_cnt = 524), go to IDLE. Otherwise stay in RUN.
  - en deasserted mid-frame: the current frame completes in full; no truncated frame.
  - en toggling within a frame has no effect; only the value at the frame end matters.
- Address generation:
  - SRC_W = H_ACTIVE >> SHIFT (320).
  - rd_addr = line_base + (h_cnt >> SHIFT), registered.
  - rd_en = 1 for exactly the active-region cycles.
  - line_base resets to 0 at v_cnt = 0.
  - line_base += SRC_W at the end of each active line where (v_cnt & (2^SHIFT - 1)) = 2^SHIFT - 1.
  - Address range 0..76799; the maximum address occurs at the last active pixel of the frame.
- Pipeline:
  - Timing signals (hsync, vsync, vde, frame-start) pass through a (1 + RD_LAT)-stage delay.
  - rgb latches rd_data when the delayed vde = 1; otherwise rgb = 0.
  - Outputs lag the counters by 1 + RD_LAT cycles; all outputs are mutually aligned.
- start_frame: asserted coincident with o_vde for the first active pixel (h = 0, v = 0) of each frame.
- Leaving RUN for IDLE: pipeline stages drain, then outputs hold their reset values.

Optional Feature:
- Macro: BRAM2RGB_TEST_PATTERN_EN.
- Defined:
  - Adds input i_pattern (1 bit).
  - When i_pattern = 1, rd_en is held 0 and rgb shows 8 vertical colour bars, each H_ACTIVE/8 = 80 pixels wide.
  - Bar order: white, yellow, cyan, green, magenta, red, blue, black; components 8'hFF or 8'h00.
  - Timing, latency and start_frame are identical to BRAM mode.
- Undefined: no i_pattern port; rgb always comes from rd_data.

Test Plan:
- Reset held, en = 1 -> all outputs at reset values, rd_en = 0; release rstb -> first rd_en at the cycle after RUN is entered.
- Run 2 frames -> hsync low for 96 cycles every 800; vsync low for 1600 cycles every 420000; o_vde high for 307200 cycles per frame.
- Monitor the rd_addr sequence -> lines 0 and 1 read 0,0,1,1,...,319,319; line 2 starts at 320; last address 76799; back to 0 next frame.
- BRAM model returns {addr[7:0], ~addr[7:0], 8'h5A}, RD_LAT = 1 and RD_LAT = 2 -> rgb matches the model exactly while o_vde = 1; first pixel aligned with the start_frame pulse.
- Drop en at v_cnt = 100 -> frame completes to v_cnt = 524, then IDLE: syncs inactive, no rd_en; reassert en -> new frame begins with start_frame.
- With BRAM2RGB_TEST_PATTERN_EN and i_pattern = 1 -> pixel 0 = FFFFFF, pixel 80 = FFFF00, pixel 639 = 000000; rd_en stays 0.
